// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// Optional RUN-phase watchdog enabled by defining CNT_SCHED_WATCHDOG_EN.
module counter_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  error,
  output logic                  cnt_reset,
  output logic                  cnt_enable,
  input  logic [CNT_W-1:0]      cnt_value
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             req_g;

`ifdef CNT_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = CNT_W + 2;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((2 ** CNT_W) + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;
`endif

  // Round-robin search starting just after the last served requester
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((32'(rr_q) + off) % NREQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign req_g = req[idx_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    len_d      = len_q;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
`ifdef CNT_SCHED_WATCHDOG_EN
    wd_d       = wd_q;
    error_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_CLEAR;
          grant_d = NREQ'(1) << pick_idx;
          idx_d   = pick_idx;
          rr_d    = pick_idx;
          len_d   = req_len[32'(pick_idx)*CNT_W +: CNT_W];
`ifdef CNT_SCHED_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      S_CLEAR: begin
        cnt_reset = 1'b1;
        if (!req_g) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A dropped request aborts even when the target is reached
        if (!req_g) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (cnt_value == len_q) begin
          state_d = S_DONE;
`ifdef CNT_SCHED_WATCHDOG_EN
        end else if (wd_q >= WD_LIMIT) begin
          state_d = S_DONE;
          error_d = 1'b1;
`endif
        end else begin
          cnt_enable = 1'b1;
`ifdef CNT_SCHED_WATCHDOG_EN
          wd_d       = wd_q + WD_W'(1);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    done_d = (state_d == S_DONE) ? grant_q : '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      rr_q    <= IDX_W'(NREQ - 1);
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
    end
  end

`ifdef CNT_SCHED_WATCHDOG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one first_counter-style up-counter among NREQ requesters.
- Each requester asks for a count run of a given length. The scheduler grants one requester, then clears and enables the counter until the requested value is reached, then signals done.
- Sits between client blocks and the shared counter datapath, and drives the counter's synchronous reset and enable inputs.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CNT_W, 3, counter width; must match the shared counter's output width

Ports:
- clock  input  1  design clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request; held high until done or abort
- req_len  input  NREQ*CNT_W  per-requester target count; slice i = [i*CNT_W +: CNT_W]
- grant  output  NREQ  one-hot grant, registered
- done  output  NREQ  one-cycle completion pulse to the granted requester, registered
- busy  output  1  high whenever state != IDLE
- error  output  1  watchdog error pulse; tied 0 when the feature is compiled out
- cnt_reset  output  1  to the counter's reset input (active high, synchronous at the counter)
- cnt_enable  output  1  to the counter's enable input
- cnt_value  input  CNT_W  counter output

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; grant=0, done=0, error=0.
  - len_q=0; rr_last=NREQ-1, so req[0] has first priority.
- FSM states are IDLE, CLEAR, RUN, DONE.
- IDLE, when any req is high:
  - Select the first requester with req high, searching from rr_last+1 upward with wrap.
  - Latch its req_len into len_q, set grant to that one-hot, update rr_last to that index, go to CLEAR.
  - Request-to-grant latency is 1 cycle.
- IDLE, when no req is high: stay in IDLE.
- CLEAR:
  - cnt_reset=1, cnt_enable=0; the counter clears on this edge.
  - Next state is RUN.
- RUN:
  - cnt_reset=0.
  - If cnt_value != len_q: cnt_enable=1 and stay in RUN.
  - If cnt_value == len_q: cnt_enable=0 and go to DONE.
- DONE:
  - done[granted]=1 for exactly this cycle; cnt_enable=0.
  - grant clears at the next edge; next state is IDLE.
- Timing:
  - If grant rises in cycle 0, done is high in cycle len_q+2.
  - cnt_value is held at len_q from cycle len_q+1 onward.
- len_q=0: CLEAR, then RUN sees 0==0 immediately, then DONE. Done arrives in cycle 2 with no enable cycles.
- len_q = 2^CNT_W-1 (7): the maximum length; the counter never wraps under the scheduler's control.
- cnt_enable and cnt_reset are combinational from state, len_q and cnt_value, and are never high together.
- Abort: if req[granted] falls in CLEAR or RUN:
  - Next state is IDLE; grant clears; no done pulse.
  - cnt_enable=0 in the cycle req is low.
  - The counter keeps its value until the next CLEAR.
- req falling in the DONE cycle is ignored; done still pulses.
- Simultaneous requests: exactly one grant, chosen by the round-robin rule.
- A requester whose req stays high after done is served again only after the other active requesters.
- req_len changes after the grant are ignored, because len_q is latched.
- IDLE takes a new decision every cycle, so back-to-back service has one IDLE cycle between DONE and the next CLEAR.
- Reset asserted mid-operation: all outputs return to reset values immediately. The counter is not cleared by this block until the next CLEAR.

Optional Feature:
- Macro: CNT_SCHED_WATCHDOG_EN.
- When defined:
  - A watchdog counts RUN cycles.
  - If RUN lasts more than 2^CNT_W+1 cycles (9 at default) without cnt_value==len_q, go to DONE.
  - That DONE pulses both done[granted] and error for one cycle.
  - The watchdog clears on entry to CLEAR.
- When undefined: no watchdog logic; error is constant 0; RUN waits indefinitely.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release with req=0 -> grant=0, done=0, busy=0, cnt_enable=0, state IDLE.
- Single request: req=4'b0001, req_len[0]=5 ->
  - grant=0001 one cycle later;
  - cnt_reset high for 1 cycle, then cnt_enable high for 5 cycles;
  - done[0] pulses in cycle 7 after grant, with cnt_value=5.
- Zero and maximum lengths: req_len=0 -> done 2 cycles after grant, cnt_enable never high. req_len=7 -> done 9 cycles after grant, cnt_value=7, no wrap.
- Round-robin: req=4'b1011 held throughout, all lengths 1 -> grant order 0001, 0010, 1000, 0001, ...; each done pulses once per service.
- Abort and async reset:
  - Drop req[2] two cycles into RUN -> cnt_enable falls the same cycle, grant clears next edge, no done.
  - Assert reset=0 mid-RUN -> grant and busy fall immediately, without a clock edge.
- Watchdog (CNT_SCHED_WATCHDOG_EN defined): hold cnt_value stuck at 2 with req_len=5 -> after 10 RUN cycles, done and error pulse together; without the macro, busy stays high.
